pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central sequencer for the 5-stage pipeline. It merges hazard-unit requests, branch redirects and variable-latency instruction/data memory handshakes into one set of per-stage enable and flush signals. It sits between hazard_unit, the memory interfaces and the pipeline registers. It also keeps stall/flush performance counters and a wait-state watchdog.

Parameters:
CNT_W, 32, width of each saturating performance counter
MAX_WAIT, 64, consecutive memory-wait cycles that trip the watchdog (legal range 1 to 2^WAIT_W-1)
WAIT_W, 8, width of the wait-cycle counter

Ports:
clk  in  1  core clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
hz_stall  in  1  hazard_unit stall request (load-use/WD), i.e. its stall_if
e_br_taken  in  1  EX-stage branch/jump taken
imem_valid  in  1  instruction word for current PC is available this cycle
dmem_req  in  1  MEM stage holds a load or store
dmem_ack  in  1  data memory completes MEM-stage access this cycle
pc_en  out  1  PC register update enable
pc_redirect  out  1  PC loads branch target (valid only with pc_en)
ifid_en  out  1  IF/ID write enable
ifid_flush  out  1  IF/ID loads NOP
idex_en  out  1  ID/EX write enable
idex_flush  out  1  ID/EX loads bubble
exmem_en  out  1  EX/MEM write enable
memwb_flush  out  1  MEM/WB loads bubble
state  out  2  FSM state: 0 RUN, 1 DWAIT, 2 IWAIT, 3 DRAIN
timeout  out  1  sticky watchdog flag
stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0
redirects  out  CNT_W  saturating count of cycles with pc_redirect=1

Behaviour:
- Reset (reset=0 at clock edge): state=RUN, wait counter=0, timeout=0, both counters=0. Control outputs are combinational from state and inputs, so they follow the RUN rules immediately.
- Back stall: bstall = dmem_req & ~dmem_ack.
  - pc_en=ifid_en=idex_en=exmem_en=0, memwb_flush=1, no flushes upstream, pc_redirect=0.
  - Highest priority; e_br_taken and hz_stall are ignored. EX is frozen, so the branch re-presents itself.
- Redirect (no bstall, e_br_taken=1):
  - pc_en=1, pc_redirect=1, ifid_flush=1, idex_flush=1, ifid_en=1, idex_en=1, exmem_en=1.
  - Overrides hz_stall and imem_valid.
- Hazard stall (no bstall, no redirect, hz_stall=1):
  - pc_en=0, ifid_en=0, idex_flush=1, idex_en=1, exmem_en=1.
- Fetch wait (none of the above, imem_valid=0):
  - pc_en=0, ifid_en=1, ifid_flush=1, downstream enables 1.
- Normal: all enables 1, all flushes 0, pc_redirect=0.
- FSM transitions, evaluated each edge (reset aside):
  - Any state → DWAIT when bstall.
  - RUN or DWAIT, no bstall: redirect with imem_valid=0 → DRAIN. Otherwise imem_valid=0 → IWAIT. Otherwise → RUN.
  - IWAIT, no bstall: redirect → DRAIN. Otherwise imem_valid=1 → RUN. Otherwise stay.
  - DRAIN (stale fetch outstanding):
    - Decode is fed NOPs: ifid_flush=1, pc_en=0.
    - On imem_valid=1 the word is discarded; ifid_flush=1 remains asserted that cycle.
    - pc_en=0 that cycle, so the PC does not advance past the target; next state RUN.
    - A new redirect in DRAIN stays in DRAIN and sets pc_en=1, pc_redirect=1.
- Watchdog:
  - The wait counter increments each cycle in DWAIT or IWAIT while the wait persists, and clears on any transition to RUN.
  - When the counter reaches MAX_WAIT, timeout is set; it is cleared only by reset.
  - The counter saturates at MAX_WAIT.
- Counters:
  - stall_cycles increments when pc_en=0 and pc_redirect=0.
  - redirects increments when pc_redirect=1.
  - Both saturate at all-ones and never wrap.
- Reset mid-operation: state, counters and timeout clear on that edge regardless of in-flight handshakes. Memory-side abandonment is the memory interface's responsibility.

Test Plan:
1. Reset, then imem_valid=1 with all other inputs 0 → state=RUN; all enables 1, all flushes 0; counters stay 0 over 10 cycles.
2. dmem_req=1, dmem_ack=0 for 3 cycles, then ack=1 → pc_en/ifid_en/idex_en/exmem_en=0 and memwb_flush=1 for 3 cycles; state=DWAIT; stall_cycles=3; RUN after ack.
3. hz_stall=1 for one cycle → pc_en=0, ifid_en=0, idex_flush=1; stall_cycles +1; state stays RUN.
4. imem_valid=0 plus e_br_taken=1 in one cycle, then imem_valid=1 two cycles later → pc_redirect=1, state=DRAIN, ifid_flush held until the stale word is discarded, then RUN; redirects=1.
5. e_br_taken=1 with dmem_req=1, dmem_ack=0 → no redirect while stalled; redirect asserts in the cycle dmem_ack=1.
6. MAX_WAIT=4, dmem_ack held 0 → timeout rises after the 4th wait cycle and stays 1 after the stall ends; clears only on reset=0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// ============================================================================
// Module      : pipeline_ctrl
// Description : 5-stage pipeline sequencer. It turns hazard, branch and
//               memory handshake inputs into per-stage enables and flushes,
//               and keeps stall/redirect counters and a wait watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl #(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 64,
    parameter int WAIT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hz_stall,
    input  logic             e_br_taken,
    input  logic             imem_valid,
    input  logic             dmem_req,
    input  logic             dmem_ack,
    output logic             pc_en,
    output logic             pc_redirect,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_flush,
    output logic [1:0]       state,
    output logic             timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] redirects
);

    localparam logic [1:0]        c_st_run   = 2'd0;
    localparam logic [1:0]        c_st_dwait = 2'd1;
    localparam logic [1:0]        c_st_iwait = 2'd2;
    localparam logic [1:0]        c_st_drain = 2'd3;
    localparam logic [WAIT_W-1:0] c_wait_max = WAIT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0]  c_cnt_max  = '1;

    logic [1:0]        r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_timeout;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_redir_cnt;

    logic              w_bstall;
    logic [1:0]        w_state_nxt;
    logic              w_waiting;
    logic [WAIT_W-1:0] w_wait_inc;

    assign w_bstall = dmem_req & ~dmem_ack;

    // Priority: back stall > redirect > drain > hazard > fetch wait > normal.
    always_comb begin
        pc_en       = 1'b1;
        pc_redirect = 1'b0;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_en    = 1'b1;
        memwb_flush = 1'b0;
        if (w_bstall) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (e_br_taken) begin
            pc_redirect = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end else if (r_state == c_st_drain) begin
            // Stale fetch word is dropped and the PC holds the branch target.
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
        end else if (hz_stall) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (!imem_valid) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_bstall) begin
            w_state_nxt = c_st_dwait;
        end else begin
            case (r_state)
                c_st_run, c_st_dwait: begin
                    if (e_br_taken && !imem_valid) w_state_nxt = c_st_drain;
                    else if (!imem_valid)          w_state_nxt = c_st_iwait;
                    else                           w_state_nxt = c_st_run;
                end
                c_st_iwait: begin
                    if (e_br_taken)      w_state_nxt = c_st_drain;
                    else if (imem_valid) w_state_nxt = c_st_run;
                end
                default: begin
                    if (e_br_taken)      w_state_nxt = c_st_drain;
                    else if (imem_valid) w_state_nxt = c_st_run;
                end
            endcase
        end
    end

    // A wait cycle counts only when a wait state carries on into a wait state.
    assign w_waiting  = ((r_state == c_st_dwait) || (r_state == c_st_iwait)) &&
                        ((w_state_nxt == c_st_dwait) || (w_state_nxt == c_st_iwait));
    assign w_wait_inc = (r_wait_cnt == c_wait_max) ? r_wait_cnt
                                                   : r_wait_cnt + WAIT_W'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= c_st_run;
            r_wait_cnt  <= '0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
            r_redir_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt == c_st_run) begin
                r_wait_cnt <= '0;
            end else if (w_waiting) begin
                r_wait_cnt <= w_wait_inc;
                if (w_wait_inc == c_wait_max) r_timeout <= 1'b1;
            end
            if (!pc_en && !pc_redirect && (r_stall_cnt != c_cnt_max))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (pc_redirect && (r_redir_cnt != c_cnt_max))
                r_redir_cnt <= r_redir_cnt + CNT_W'(1);
        end
    end

    assign state        = r_state;
    assign timeout      = r_timeout;
    assign stall_cycles = r_stall_cnt;
    assign redirects    = r_redir_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Directed scoreboard bench for pipeline_ctrl (wide counters
//               and 3-bit counters side by side, watchdog at 4 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_ctrl;

    localparam logic [7:0] c_NORM = 8'b1010_1010;
    localparam logic [7:0] c_BST  = 8'b0000_0001;
    localparam logic [7:0] c_RED  = 8'b1111_1110;
    localparam logic [7:0] c_HAZ  = 8'b0000_1110;
    localparam logic [7:0] c_FW   = 8'b0011_1010;
    localparam logic [1:0] c_RUN  = 2'd0;
    localparam logic [1:0] c_DW   = 2'd1;
    localparam logic [1:0] c_IW   = 2'd2;
    localparam logic [1:0] c_DR   = 2'd3;

    logic clk = 1'b0;
    logic reset, hz_stall, e_br_taken, imem_valid, dmem_req, dmem_ack;

    logic        pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush;
    logic [1:0]  state;
    logic        timeout;
    logic [31:0] stall_cycles, redirects;

    logic        s_pc_en, s_pc_redirect, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush, s_exmem_en, s_memwb_flush;
    logic [1:0]  s_state;
    logic        s_timeout;
    logic [2:0]  s_stall_cycles, s_redirects;

    logic [7:0]  w_ctl, w_ctl_s;

    typedef struct {
        logic [7:0]  ctrl;
        logic [1:0]  st;
        logic        to;
        logic [31:0] sc;
        logic [31:0] rc;
        logic [31:0] sc_s;
        logic [31:0] rc_s;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_sc, exp_rc, exp_sc_s, exp_rc_s;

    always #5 clk = ~clk;

    pipeline_ctrl #(.CNT_W(32), .MAX_WAIT(4), .WAIT_W(8)) dut (
        .clk(clk), .reset(reset), .hz_stall(hz_stall), .e_br_taken(e_br_taken),
        .imem_valid(imem_valid), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .pc_en(pc_en), .pc_redirect(pc_redirect), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en), .memwb_flush(memwb_flush),
        .state(state), .timeout(timeout), .stall_cycles(stall_cycles), .redirects(redirects)
    );

    pipeline_ctrl #(.CNT_W(3), .MAX_WAIT(4), .WAIT_W(8)) dut_s (
        .clk(clk), .reset(reset), .hz_stall(hz_stall), .e_br_taken(e_br_taken),
        .imem_valid(imem_valid), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
        .pc_en(s_pc_en), .pc_redirect(s_pc_redirect), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush),
        .idex_en(s_idex_en), .idex_flush(s_idex_flush), .exmem_en(s_exmem_en), .memwb_flush(s_memwb_flush),
        .state(s_state), .timeout(s_timeout), .stall_cycles(s_stall_cycles), .redirects(s_redirects)
    );

    assign w_ctl   = {pc_en, pc_redirect, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush};
    assign w_ctl_s = {s_pc_en, s_pc_redirect, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush, s_exmem_en, s_memwb_flush};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_regs(input exp_t e);
        chk("state",   32'(state),          32'(e.st));
        chk("timeout", 32'(timeout),        32'(e.to));
        chk("stall",   stall_cycles,        e.sc);
        chk("redir",   redirects,           e.rc);
        chk("state_s", 32'(s_state),        32'(e.st));
        chk("to_s",    32'(s_timeout),      32'(e.to));
        chk("stall_s", 32'(s_stall_cycles), e.sc_s);
        chk("redir_s", 32'(s_redirects),    e.rc_s);
    endtask

    // Reset held low across one edge; the block then sits in RUN.
    task automatic do_reset(input logic req, input logic ack, input logic [7:0] ectl);
        exp_t e;
        @(negedge clk);
        reset = 1'b0; hz_stall = 1'b0; e_br_taken = 1'b0; imem_valid = 1'b1;
        dmem_req = req; dmem_ack = ack;
        exp_sc = 0; exp_rc = 0; exp_sc_s = 0; exp_rc_s = 0;
        e = '{ectl, c_RUN, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0};
        sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front();
        check_regs(e);
        chk("rst_ctrl",   32'(w_ctl),   32'(e.ctrl));
        chk("rst_ctrl_s", 32'(w_ctl_s), 32'(e.ctrl));
    endtask

    task automatic step(input logic hz, input logic br, input logic iv, input logic req, input logic ack,
                        input logic [7:0] ectl, input logic [1:0] est, input logic eto);
        exp_t e;
        @(negedge clk);
        reset = 1'b1; hz_stall = hz; e_br_taken = br; imem_valid = iv;
        dmem_req = req; dmem_ack = ack;
        if (!ectl[7] && !ectl[6]) begin
            exp_sc++;
            if (exp_sc_s != 32'd7) exp_sc_s++;
        end
        if (ectl[6]) begin
            exp_rc++;
            if (exp_rc_s != 32'd7) exp_rc_s++;
        end
        e = '{ectl, est, eto, exp_sc, exp_rc, exp_sc_s, exp_rc_s};
        sb.push_back(e);
        #2;
        e = sb.pop_front();
        chk("ctrl",   32'(w_ctl),   32'(e.ctrl));
        chk("ctrl_s", 32'(w_ctl_s), 32'(e.ctrl));
        @(posedge clk); #1;
        check_regs(e);
    endtask

    initial begin
        reset = 1'b0; hz_stall = 1'b0; e_br_taken = 1'b0; imem_valid = 1'b1;
        dmem_req = 1'b0; dmem_ack = 1'b0;
        exp_sc = 0; exp_rc = 0; exp_sc_s = 0; exp_rc_s = 0;

        do_reset(1'b0, 1'b0, c_NORM);

        // Normal flow
        repeat (10) step(0, 0, 1, 0, 0, c_NORM, c_RUN, 0);

        // Data memory back stall then ack
        repeat (3) step(0, 0, 1, 1, 0, c_BST, c_DW, 0);
        step(0, 0, 1, 1, 1, c_NORM, c_RUN, 0);

        // Single-cycle hazard stall
        step(1, 0, 1, 0, 0, c_HAZ, c_RUN, 0);
        step(0, 0, 1, 0, 0, c_NORM, c_RUN, 0);

        // Redirect while fetch outstanding -> drain, discard stale word
        step(0, 1, 0, 0, 0, c_RED, c_DR, 0);
        step(0, 0, 0, 0, 0, c_FW, c_DR, 0);
        step(0, 0, 1, 0, 0, c_FW, c_RUN, 0);
        step(0, 0, 1, 0, 0, c_NORM, c_RUN, 0);

        // Fetch wait, redirect from IWAIT, re-redirect inside DRAIN
        step(0, 0, 0, 0, 0, c_FW, c_IW, 0);
        step(0, 0, 0, 0, 0, c_FW, c_IW, 0);
        step(0, 1, 0, 0, 0, c_RED, c_DR, 0);
        step(0, 1, 1, 0, 0, c_RED, c_DR, 0);
        step(0, 0, 1, 0, 0, c_FW, c_RUN, 0);

        // Hazard outranks fetch wait
        step(1, 0, 0, 0, 0, c_HAZ, c_IW, 0);
        step(0, 0, 1, 0, 0, c_NORM, c_RUN, 0);

        // Branch held behind a back stall, redirect on ack
        step(0, 1, 1, 1, 0, c_BST, c_DW, 0);
        step(0, 1, 1, 1, 0, c_BST, c_DW, 0);
        step(0, 1, 1, 1, 1, c_RED, c_RUN, 0);
        step(0, 0, 1, 0, 0, c_NORM, c_RUN, 0);

        // Watchdog trips on 4th DWAIT cycle and stays sticky
        repeat (4) step(0, 0, 1, 1, 0, c_BST, c_DW, 0);
        repeat (2) step(0, 0, 1, 1, 0, c_BST, c_DW, 1);
        step(0, 0, 1, 1, 1, c_NORM, c_RUN, 1);
        step(0, 0, 1, 0, 0, c_NORM, c_RUN, 1);

        // Reset mid-stall clears state, counters and timeout
        do_reset(1'b1, 1'b0, c_BST);
        step(0, 0, 1, 1, 0, c_BST, c_DW, 0);
        step(0, 0, 1, 1, 1, c_NORM, c_RUN, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
